// File: rtl/instr_register_pkg.sv
// instr_register_pkg: shared instruction-register types plus execution-stage additions.
package instr_register_pkg;
    localparam int OPERAND_W = 32;
    localparam int RESULT_W = 64;
    localparam int ADDR_W = 5;
    typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
    typedef logic signed [OPERAND_W-1:0] operand_t;
    typedef logic signed [RESULT_W-1:0] result_t;
    typedef logic [ADDR_W-1:0] address_t;
    typedef struct packed {
        operand_t op_a;
        operand_t op_b;
        opcode_t opc;
        result_t result;
    } instruction_t;
    typedef enum logic [1:0] {EX_IDLE, EX_DIVIDE, EX_DONE} exec_state_t;
    function automatic result_t sext(input operand_t v);
        return {{(RESULT_W-OPERAND_W){v[OPERAND_W-1]}}, v};
    endfunction
endpackage

// File: rtl/instr_seq_divider.sv
// instr_seq_divider: iterative restoring signed divide/modulo on operand magnitudes.
module instr_seq_divider
    import instr_register_pkg::*;
#(
    parameter int DIV_STEPS_PER_CYCLE = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     start,
    input  operand_t dividend,
    input  operand_t divisor,
    input  logic     is_mod,
    output logic     done,
    output result_t  result
);
    localparam int CYCLES = OPERAND_W / DIV_STEPS_PER_CYCLE;

    if (DIV_STEPS_PER_CYCLE != 1 && DIV_STEPS_PER_CYCLE != 2 &&
        DIV_STEPS_PER_CYCLE != 4 && DIV_STEPS_PER_CYCLE != 8) begin : g_bad_steps
        $error("DIV_STEPS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    logic [OPERAND_W-1:0] rem, quo, den, rem_n, quo_n, mag_res;
    logic [OPERAND_W:0] diff;
    logic [RESULT_W-1:0] ext;
    logic [5:0] cnt;
    logic run, neg_q, neg_r, mod_r;

    function automatic logic [OPERAND_W-1:0] mag(input operand_t v);
        return v[OPERAND_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    always_comb begin
        rem_n = rem;
        quo_n = quo;
        diff = '0;
        for (int i = 0; i < DIV_STEPS_PER_CYCLE; i++) begin
            diff = {rem_n, quo_n[OPERAND_W-1]} - {1'b0, den};
            rem_n = diff[OPERAND_W] ? {rem_n[OPERAND_W-2:0], quo_n[OPERAND_W-1]} : diff[OPERAND_W-1:0];
            quo_n = {quo_n[OPERAND_W-2:0], ~diff[OPERAND_W]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem <= '0;
            quo <= '0;
            den <= '0;
            cnt <= '0;
            run <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            mod_r <= 1'b0;
        end else if (start) begin
            rem <= '0;
            quo <= mag(dividend);
            den <= mag(divisor);
            cnt <= '0;
            run <= 1'b1;
            neg_q <= dividend[OPERAND_W-1] ^ divisor[OPERAND_W-1];
            neg_r <= dividend[OPERAND_W-1];
            mod_r <= is_mod;
        end else if (run) begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt + 6'd1;
            run <= cnt != 6'(CYCLES-1);
        end
    end

    // Result is taken from the final step's combinational output so the top can register it on the same edge.
    assign done = run && cnt == 6'(CYCLES-1);
    assign mag_res = mod_r ? rem_n : quo_n;
    assign ext = {{(RESULT_W-OPERAND_W){1'b0}}, mag_res};
    assign result = (mod_r ? neg_r : neg_q) ? -ext : ext;
endmodule

// File: rtl/instr_exec_unit.sv
// instr_exec_unit: executes one instruction per handshake; single-cycle ALU plus iterative divider.
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int DIV_STEPS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  instruction_t in_instr,
    input  address_t     in_addr,
    output logic         out_valid,
    input  logic         out_ready,
    output result_t      out_result,
    output address_t     out_addr,
    output opcode_t      out_opc,
    output logic         out_err,
    output logic         busy
);
    exec_state_t state;
    result_t a, b, alu_res, div_result;
    logic accept, div_start, div_done, alu_err, unused_result;

    assign a = sext(in_instr.op_a);
    assign b = sext(in_instr.op_b);
    assign accept = in_valid && in_ready;
    assign div_start = accept && (in_instr.opc == DIV || in_instr.opc == MOD) && in_instr.op_b != '0;
    assign unused_result = ^in_instr.result;

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (in_instr.opc)
            ZERO:     alu_res = '0;
            PASSA:    alu_res = a;
            PASSB:    alu_res = b;
            ADD:      alu_res = a + b;
            SUB:      alu_res = a - b;
            MULT:     alu_res = a * b;
            DIV, MOD: alu_err = in_instr.op_b == '0;
            default:  alu_err = 1'b1;
        endcase
    end

    instr_seq_divider #(.DIV_STEPS_PER_CYCLE(DIV_STEPS_PER_CYCLE)) u_div (
        .clk(clk),
        .reset(reset),
        .start(div_start),
        .dividend(in_instr.op_a),
        .divisor(in_instr.op_b),
        .is_mod(in_instr.opc == MOD),
        .done(div_done),
        .result(div_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EX_IDLE;
            out_result <= '0;
            out_addr <= '0;
            out_opc <= ZERO;
            out_err <= 1'b0;
        end else begin
            case (state)
                EX_IDLE: if (accept) begin
                    out_result <= alu_res;
                    out_err <= alu_err;
                    out_addr <= in_addr;
                    out_opc <= in_instr.opc;
                    state <= div_start ? EX_DIVIDE : EX_DONE;
                end
                EX_DIVIDE: if (div_done) begin
                    out_result <= div_result;
                    state <= EX_DONE;
                end
                EX_DONE: if (out_ready) state <= EX_IDLE;
                default: state <= EX_IDLE;
            endcase
        end
    end

    assign in_ready = state == EX_IDLE && !reset;
    assign out_valid = state == EX_DONE;
    assign busy = state != EX_IDLE;
endmodule

// File: doc/instr_exec_unit.md
# instr_exec_unit

Execution stage downstream of the instruction register. It accepts one `instruction_t` plus its register address over a valid/ready handshake and computes the signed 64-bit result. The result goes out with the same address over a second valid/ready handshake, so it can be written back into the `result` field of that register slot. ZERO/PASSA/PASSB/ADD/SUB/MULT complete in one cycle; DIV/MOD use an iterative divider.

## Interface
Parameters:
- `DIV_STEPS_PER_CYCLE`, default 1: quotient bits resolved per divider cycle. Legal values are 1, 2, 4 and 8; any other value is an elaboration error.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream presents an instruction.
- `in_ready`  out  1  unit can accept.
- `in_instr`  in  `instruction_t`  instruction; `result` field ignored.
- `in_addr`  in  `address_t`  register slot of the instruction.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream takes the result.
- `out_result`  out  `result_t`  signed result.
- `out_addr`  out  `address_t`  copy of the accepted `in_addr`.
- `out_opc`  out  `opcode_t`  copy of the accepted opcode.
- `out_err`  out  1  divide-by-zero or illegal opcode.
- `busy`  out  1  state is not EX_IDLE.

## Operation
- FSM states:
  - EX_IDLE → EX_DIVIDE on accept of DIV/MOD with `op_b` ≠ 0.
  - EX_IDLE → EX_DONE on any other accept.
  - EX_DIVIDE → EX_DONE after 32/`DIV_STEPS_PER_CYCLE` cycles.
  - EX_DONE → EX_IDLE when `out_ready` is 1.
- Handshake signals:
  - `in_ready` = (state == EX_IDLE) and not in reset.
  - Accept happens on a cycle with `in_valid` && `in_ready`.
  - `out_valid` = (state == EX_DONE).
- Inputs are captured on accept. Later changes on `in_*` have no effect.
- Arithmetic: operands are sign-extended to 64 bits before the operation.
  - ZERO → 0.
  - PASSA → `op_a`.
  - PASSB → `op_b`.
  - ADD → a+b.
  - SUB → a−b.
  - MULT → full signed 64-bit product. It never overflows.
- DIV/MOD:
  - Unsigned restoring division of |a| by |b|.
  - Quotient sign = sign(a) XOR sign(b); truncation is toward zero.
  - Remainder sign = sign(a).
  - The result is sign-extended to 64 bits.
  - a = −2^31, b = −1 gives DIV = +2147483648 and MOD = 0, with no error.
- Divide by zero: DIV/MOD with `op_b` = 0 goes straight to EX_DONE with result 0 and `out_err` = 1.
- Illegal opcode (encodings 8–15): result 0, `out_err` = 1.
- `out_err` is 0 for every other case.

## Timing
- Reset (asynchronous, immediate):
  - State goes to EX_IDLE and any divide in progress is dropped.
  - `out_valid` = 0, `out_result` = 0, `out_addr` = 0, `out_opc` = ZERO, `out_err` = 0, `busy` = 0.
  - `in_ready` is 0 while reset is high and 1 on the first cycle after release.
- Non-divide latency: accept at edge N gives `out_valid` = 1 after edge N+1.
- Divide latency (`op_b` ≠ 0): `out_valid` after edge N+1+32/`DIV_STEPS_PER_CYCLE`. For `DIV_STEPS_PER_CYCLE` = 1 that is 33 cycles.
- Output hold: while `out_valid` && !`out_ready`, all `out_*` signals stay stable.
- Back-to-back: the earliest next accept is the cycle after the output handshake completes. Peak throughput is therefore one instruction every 2 cycles.
- Upstream stalls: `in_valid` high in EX_DIVIDE or EX_DONE is ignored, with no capture. Upstream holds its data until it sees `in_ready`.
- A reset asserted during EX_DIVIDE or EX_DONE with `out_valid` high discards the pending result. No handshake occurs.

## Structure
- Additions to the shared `instr_register_pkg`:
  - `typedef enum logic [1:0] {EX_IDLE, EX_DIVIDE, EX_DONE} exec_state_t`.
  - `localparam int OPERAND_W = 32`.
- One sub-module, `instr_seq_divider`:
  - Inputs: start, dividend, divisor, `is_mod`.
  - Outputs: `done` and the signed 64-bit result.
  - Holds the magnitude remainder/quotient registers and the step counter.
  - Is parameterised by `DIV_STEPS_PER_CYCLE`.
  - Uses the same `clk`/`reset`.
- The top level holds the FSM, the capture registers and the single-cycle ALU.

## Test plan
- Reset then ADD, a = 7, b = −10, addr 3 → `out_valid` at N+1, result −3, `out_addr` 3, `out_err` 0; outputs are all-zero during reset.
- MULT, a = −2147483648, b = −2147483648 → result 4611686018427387904, `out_err` 0.
- DIV and MOD with a = −7, b = 2 → results −3 and −1 after 33 cycles. Then a = −2^31, b = −1 → DIV +2147483648, MOD 0.
- DIV with b = 0, and opcode 4'hC → result 0, `out_err` 1, latency 1. Unit then returns to EX_IDLE.
- Hold `out_ready` = 0 for 5 cycles while `in_valid` toggles with new data → `out_*` stable, `in_ready` stays 0, no capture. After `out_ready` the next instruction is accepted.
- Assert `reset` at cycle 10 of a DIV → `out_valid` 0 immediately. A PASSB, b = 42 sent after release → result 42 at N+1.
